// File: rtl/fir_mac_sequencer_if.sv
// Sample, coefficient-write and result signals of the serial FIR controller.
// The master side drives samples and coefficients; the slave side is the filter.
interface fir_mac_sequencer_if #(
   parameter int DATAWIDTH = 8,
   parameter int AW        = 3
);
   logic                        in_valid;
   logic                        in_ready;
   logic signed [DATAWIDTH-1:0] x_in;
   logic                        coef_we;
   logic [AW-1:0]               coef_addr;
   logic signed [DATAWIDTH-1:0] coef_wdata;
   logic                        out_valid;
   logic signed [DATAWIDTH-1:0] y_out;
   logic                        busy;

   modport master (
      output in_valid, x_in, coef_we, coef_addr, coef_wdata,
      input  in_ready, out_valid, y_out, busy
   );

   modport slave (
      input  in_valid, x_in, coef_we, coef_addr, coef_wdata,
      output in_ready, out_valid, y_out, busy
   );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Serial FIR: one signed multiply-accumulate shared across N_TAPS taps per sample,
// with a circular sample history and a coefficient bank writable while idle.
module fir_mac_sequencer #(
   parameter int N_TAPS    = 5,
   parameter int DATAWIDTH = 8,
   parameter int ACCWIDTH  = 19,
   parameter int AW        = 3
) (
   input logic                clk,
   input logic                rst,
   fir_mac_sequencer_if.slave bus
);
   localparam int KW = $clog2(N_TAPS);
   localparam logic [KW-1:0] K_LAST = KW'(N_TAPS - 1);
   localparam logic [KW-1:0] K_SPAN = KW'(N_TAPS);
   localparam logic [AW-1:0] A_LAST = AW'(N_TAPS - 1);

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   state_t                        state, state_next;
   logic                          ready;
   logic                          accept;
   logic                          coef_ok;
   logic [KW-1:0]                 k;
   logic [KW-1:0]                 wr_ptr;
   logic [KW-1:0]                 rd_idx;
   logic signed [ACCWIDTH-1:0]    acc;
   logic signed [2*DATAWIDTH-1:0] prod;
   logic signed [DATAWIDTH-1:0]   hist [N_TAPS];
   logic signed [DATAWIDTH-1:0]   coef [N_TAPS];
   logic signed [DATAWIDTH-1:0]   y_reg;
   logic                          out_valid_reg;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      ready      = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (bus.in_valid) state_next = MAC;
         end
         MAC:     if (k == K_LAST) state_next = OUT;
         OUT:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign accept  = bus.in_valid && ready;
   assign coef_ok = bus.coef_we && ready && (bus.coef_addr <= A_LAST);

   // Modular wrap works without a power-of-two depth: add the span back when k exceeds wr_ptr.
   assign rd_idx = (wr_ptr >= k) ? (wr_ptr - k) : (wr_ptr + K_SPAN - k);
   assign prod   = coef[k] * hist[rd_idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         acc           <= '0;
         k             <= '0;
         wr_ptr        <= '0;
         y_reg         <= '0;
         out_valid_reg <= 1'b0;
         for (int unsigned i = 0; i < N_TAPS; i++) begin
            hist[i] <= '0;
            coef[i] <= '0;
         end
      end else begin
         out_valid_reg <= 1'b0;
         case (state)
            IDLE: begin
               if (coef_ok) coef[bus.coef_addr[KW-1:0]] <= bus.coef_wdata;
               if (accept) begin
                  hist[wr_ptr] <= bus.x_in;
                  acc          <= '0;
                  k            <= '0;
               end
            end
            MAC: begin
               acc <= acc + ACCWIDTH'(prod);
               k   <= (k == K_LAST) ? '0 : k + 1'b1;
            end
            OUT: begin
               y_reg         <= acc[DATAWIDTH-1:0];
               out_valid_reg <= 1'b1;
               wr_ptr        <= (wr_ptr == K_LAST) ? '0 : wr_ptr + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = ready;
   assign bus.busy      = !ready;
   assign bus.out_valid = out_valid_reg;
   assign bus.y_out     = y_reg;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer: impulse/step responses, truncation,
// streaming handshake against a convolution model, busy-write drops and mid-MAC reset.
module tb_fir_mac_sequencer;
   localparam int N  = 5;
   localparam int DW = 8;
   localparam int AW = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   fir_mac_sequencer_if #(.DATAWIDTH(DW), .AW(AW)) bus ();

   fir_mac_sequencer #(
      .N_TAPS(N), .DATAWIDTH(DW), .ACCWIDTH(19), .AW(AW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic write_coef(input int addr, input int val);
      @(negedge clk);
      bus.coef_we    = 1'b1;
      bus.coef_addr  = AW'(addr);
      bus.coef_wdata = DW'(val);
      @(negedge clk);
      bus.coef_we    = 1'b0;
   endtask

   // Returns 9999 if the sample is never accepted or no result appears.
   task automatic run_sample(input int x, output int y);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      bus.in_valid = 1'b1;
      bus.x_in     = DW'(x);
      @(negedge clk);
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      y = bus.out_valid ? int'(bus.y_out) : 9999;
   endtask

   int y;
   int cf [N]  = '{3, -2, 5, 1, -7};
   int xs [20] = '{12, -7, 100, -128, 127, 5, 0, -1, 33, -64,
                   77, 9, -100, 45, 2, -3, 88, -50, 19, -20};
   int gold [20];
   int acc_cyc [20];
   int imp_exp [6] = '{-4, -2, -1, 0, 0, 0};
   int stp_exp [6] = '{-40, -60, -70, -70, -70, -70};

   initial begin
      int sent, rcv, cyc, low_run, seen;
      bit prev_ov;
      bus.in_valid   = 1'b0;
      bus.x_in       = '0;
      bus.coef_we    = 1'b0;
      bus.coef_addr  = '0;
      bus.coef_wdata = '0;

      do_reset();
      check("rst_in_ready", int'(bus.in_ready), 1);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_y_out", int'(bus.y_out), 0);

      // Impulse and step with coefs {-4,-2,-1,0,0}
      write_coef(0, -4);
      write_coef(1, -2);
      write_coef(2, -1);
      write_coef(3, 0);
      write_coef(4, 0);
      for (int i = 0; i < 6; i++) begin
         run_sample((i == 0) ? 1 : 0, y);
         check($sformatf("impulse[%0d]", i), y, imp_exp[i]);
      end
      for (int i = 0; i < 6; i++) begin
         run_sample(10, y);
         check($sformatf("step[%0d]", i), y, stp_exp[i]);
      end

      // Truncation of the accumulator to the low byte
      do_reset();
      write_coef(0, -4);
      run_sample(100, y);
      check("trunc_neg400", y, 112);
      write_coef(0, -1);
      run_sample(-128, y);
      check("trunc_pos128", y, -128);

      // Streaming with in_valid held high against a convolution model
      do_reset();
      for (int i = 0; i < N; i++) write_coef(i, cf[i]);
      for (int n = 0; n < 20; n++) begin
         int a;
         a = 0;
         for (int t = 0; t < N; t++)
            if (n - t >= 0) a += cf[t] * xs[n - t];
         gold[n] = int'(byte'(a));
      end
      sent = 0; rcv = 0; cyc = 0; low_run = 0; prev_ov = 1'b0;
      while (rcv < 20 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (bus.out_valid) begin
            check("ov_pulse_width", int'(prev_ov), 0);
            if (rcv < sent) begin
               check($sformatf("stream_y[%0d]", rcv), int'(bus.y_out), gold[rcv]);
               check($sformatf("stream_lat[%0d]", rcv), cyc - acc_cyc[rcv], N + 2);
            end
            rcv++;
         end
         prev_ov = bus.out_valid;
         bus.in_valid = (sent < 20);
         bus.x_in     = DW'(xs[(sent < 20) ? sent : 19]);
         if (!bus.in_ready) low_run++;
         else if (bus.in_valid) begin
            if (sent > 0) check($sformatf("ready_low[%0d]", sent), low_run, N + 1);
            acc_cyc[sent] = cyc;
            sent++;
            low_run = 0;
         end
      end
      bus.in_valid = 1'b0;
      check("stream_count", rcv, 20);

      // Coefficient writes while busy or out of range are dropped
      do_reset();
      write_coef(0, 2);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.x_in     = DW'(1);
      @(negedge clk);
      bus.in_valid   = 1'b0;
      bus.coef_we    = 1'b1;
      bus.coef_addr  = '0;
      bus.coef_wdata = DW'(5);
      @(negedge clk);
      bus.coef_we    = 1'b0;
      y = 9999;
      for (int n = 0; n < 20 && y == 9999; n++) begin
         if (bus.out_valid) y = int'(bus.y_out);
         else @(negedge clk);
      end
      check("busy_write_dropped", y, 2);
      write_coef(0, 5);
      write_coef(5, 9);
      write_coef(6, 9);
      write_coef(7, 9);
      run_sample(1, y);
      check("idle_write_used", y, 5);
      for (int i = 0; i < 4; i++) begin
         run_sample(0, y);
         check($sformatf("oob_write_ignored[%0d]", i), y, 0);
      end

      // Reset in the middle of MAC
      do_reset();
      write_coef(0, 3);
      run_sample(1, y);
      check("pre_reset_y", y, 3);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.x_in     = DW'(1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_in_ready", int'(bus.in_ready), 1);
      check("midrst_y_out", int'(bus.y_out), 0);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.out_valid) seen++;
         @(negedge clk);
      end
      check("midrst_no_out_valid", seen, 0);
      run_sample(1, y);
      check("midrst_coef_cleared", y, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
